trap_controller: RTL and testbench
==================================

Name: trap_controller

Overview:
Sequences machine-mode trap entry and return for the 5-stage core. Samples the writeback-stage instruction's pending-exception bit, the synchronized external interrupt and MRET. It arbitrates between them by fixed priority and drives the CSR file's trap-commit strobes (controlReset, mcause, mtval, trap PC, mretSignal). It also drives pipeline flush and fetch redirect. Exceptions raised in earlier stages travel down the pipe as pending bits and take effect here only at writeback.

Parameters:
FLUSH_CYCLES, 3, cycles flush stays asserted after any redirect (≥1); the counter width is derived from it.
SYNC_STAGES, 2, flops in the interrupt synchronizer (≥1).

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high
interrupt  in  1  external interrupt, asynchronous level
writebackValid  in  1  valid instruction in writeback
writebackPC  in  32  PC of the writeback instruction
exceptionPending  in  1  writeback instruction carries an exception
exceptionCause  in  4  cause code of the pending exception
exceptionTval  in  32  trap value of the pending exception
mretValid  in  1  writeback instruction is MRET
mstatusMIE  in  1  MSTATUS[3]
mieMEIE  in  1  MIE[11]
trapVector  in  32  MTVEC value from the CSR file
mepcValue  in  32  MEPC value from the CSR file
commitSuppress  out  1  combinational; blocks register-file/CSR write of the writeback instruction
controlReset  out  1  one-cycle trap-commit strobe to the CSR file
mcause  out  4  cause code
mcauseInterrupt  out  1  interrupt bit (MCAUSE[31])
mtval  out  32  trap value
trapPC  out  32  value to write into MEPC
mretSignal  out  1  one-cycle MRET-commit strobe
redirectValid  out  1  one-cycle fetch-redirect strobe
redirectPC  out  32  fetch redirect target
flush  out  1  squash IF/ID/EX/MEM
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, flush counter 0, synchronizer flops 0. Every registered output is 0: controlReset, mcause, mcauseInterrupt, mtval, trapPC, mretSignal, redirectValid, redirectPC, flush, busy.
- The interrupt path passes through SYNC_STAGES flops, giving irqSync. irqTake = irqSync & mstatusMIE & mieMEIE.
- States are IDLE and FLUSH. Arbitration happens only in IDLE, on a cycle with writebackValid=1, combinationally in cycle N.
- Priority 1, exceptionPending:
  - commitSuppress=1 in cycle N.
  - At N+1: controlReset=1, mcause=exceptionCause, mcauseInterrupt=0, mtval=exceptionTval, trapPC=writebackPC, redirectValid=1, redirectPC=trapVector (value sampled at N).
- Priority 2, irqTake:
  - The writeback instruction is squashed: commitSuppress=1.
  - At N+1: controlReset=1, mcause=4'd11, mcauseInterrupt=1, mtval=0, trapPC=writebackPC, redirect to trapVector.
- Priority 3, mretValid:
  - The MRET instruction itself commits: commitSuppress=0.
  - At N+1: mretSignal=1, redirectValid=1, redirectPC=mepcValue (sampled at N).
- Any taken event moves the state to FLUSH at N+1.
  - flush=1 for exactly FLUSH_CYCLES cycles, N+1 through N+FLUSH_CYCLES. The counter loads FLUSH_CYCLES-1 and decrements.
  - The state returns to IDLE when the counter reaches 0, so the first arbitration is possible at N+FLUSH_CYCLES+1.
- Strobes: controlReset, mretSignal and redirectValid are single-cycle pulses. mcause, mcauseInterrupt, mtval, trapPC and redirectPC hold their last values until the next event.
- In FLUSH:
  - All writeback inputs are ignored and commitSuppress=1. Those instructions are wrong-path.
  - irqSync is not latched; a level still asserted on return to IDLE is taken then.
- With writebackValid=0 in IDLE, no event is taken, even if irqTake=1. Interrupts wait for an instruction boundary.
- Simultaneous events: exception beats interrupt beats MRET. An MRET carrying exceptionPending is treated as an exception.
- Reset asserted mid-FLUSH returns to IDLE next edge, clears the counter and drops flush.
- The block does not modify MSTATUS itself; the CSR file does that on controlReset and mretSignal.

Decomposition:
- StaticPack gains:
  - trapState_ enum {IDLE, FLUSH};
  - the constant CAUSE_MEXT_INT = 4'd11;
  - MIE_MEIE_BIT = 11 and MSTATUS_MIE_BIT = 3.
- Sub-module sync_chain (parameter STAGES): a plain flop chain for interrupt.
- The CSR file's MCAUSE write is widened to {mcauseInterrupt, 27'd0, mcause}.

Test Plan:
- Reset hold then release, with no inputs active -> all outputs 0, busy=0, flush=0 indefinitely.
- Setup: trapVector=0x80000100, FLUSH_CYCLES=3. Stimulus: writebackValid=1, exceptionPending=1, cause=2, tval=0xDEADBEEF, PC=0x00000040 at cycle N.
  - commitSuppress=1 at N.
  - At N+1: controlReset=1, mcause=2, mtval=0xDEADBEEF, trapPC=0x40, redirectPC=0x80000100.
  - flush=1 for N+1..N+3; busy=0 at N+4.
- Interrupt path:
  - interrupt=1 with MIE=1 and MEIE=1, but writebackValid=0 -> no event.
  - At the first writebackValid=1 (PC=0x60) after the 2-cycle synchronizer: mcause=11, mcauseInterrupt=1, trapPC=0x60, commitSuppress=1.
- Same cycle exceptionPending=1, irqTake=1 and mretValid=1 -> exception taken, mretSignal stays 0. With MIE=0, interrupt=1 and an exception still taken, only the exception fires.
- MRET with mepcValue=0x00000044 -> mretSignal=1 and redirectPC=0x44 at N+1, commitSuppress=0 at N. A second exception presented at N+2, during FLUSH, is ignored.
- reset asserted at N+2 during FLUSH -> flush=0 and busy=0 at N+3. A new exception at N+4 is taken normally.

Source files
------------

// File: rtl/trap_controller_pkg.sv
// trap_controller_pkg: shared state encoding and CSR constants for trap sequencing
package trap_controller_pkg;

    typedef enum logic {
        IDLE,
        FLUSH
    } trapState_;

    localparam logic [3:0] CAUSE_MEXT_INT  = 4'd11;
    localparam int         MIE_MEIE_BIT    = 11;
    localparam int         MSTATUS_MIE_BIT = 3;

endpackage

// File: rtl/trap_controller_if.sv
// trap_controller_if: writeback/CSR/fetch signals between the core and trap_controller
// Inputs to the controller: writeback instruction state, CSR enables and vectors.
// Outputs from the controller: commit suppression, CSR trap/MRET strobes, redirect and flush.
interface trap_controller_if;
    logic        writebackValid;
    logic [31:0] writebackPC;
    logic        exceptionPending;
    logic [3:0]  exceptionCause;
    logic [31:0] exceptionTval;
    logic        mretValid;
    logic        mstatusMIE;
    logic        mieMEIE;
    logic [31:0] trapVector;
    logic [31:0] mepcValue;
    logic        commitSuppress;
    logic        controlReset;
    logic [3:0]  mcause;
    logic        mcauseInterrupt;
    logic [31:0] mtval;
    logic [31:0] trapPC;
    logic        mretSignal;
    logic        redirectValid;
    logic [31:0] redirectPC;
    logic        flush;
    logic        busy;

    modport slave (
        input  writebackValid, writebackPC, exceptionPending, exceptionCause, exceptionTval,
               mretValid, mstatusMIE, mieMEIE, trapVector, mepcValue,
        output commitSuppress, controlReset, mcause, mcauseInterrupt, mtval, trapPC,
               mretSignal, redirectValid, redirectPC, flush, busy
    );

    modport master (
        output writebackValid, writebackPC, exceptionPending, exceptionCause, exceptionTval,
               mretValid, mstatusMIE, mieMEIE, trapVector, mepcValue,
        input  commitSuppress, controlReset, mcause, mcauseInterrupt, mtval, trapPC,
               mretSignal, redirectValid, redirectPC, flush, busy
    );
endinterface

// File: rtl/trap_controller_sync_chain.sv
// trap_controller_sync_chain: STAGES-deep flop chain synchronizing an asynchronous level
// Ports: i_clock, i_reset (sync, active-high), i_d async input, o_q synchronized output.
module trap_controller_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_d;
            for (int k = 1; k < STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/trap_controller.sv
// trap_controller: arbitrates writeback exceptions, external interrupts and MRET into CSR strobes and redirects
// Ports: i_clock, i_reset (sync, active-high), i_interrupt async level,
// bus (slave) carrying writeback/CSR inputs and trap/redirect/flush outputs.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int FLUSH_CYCLES = 3,
    parameter int SYNC_STAGES  = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_interrupt,
    trap_controller_if.slave   bus
);
    localparam int            CW   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(FLUSH_CYCLES - 1);

    trapState_   r_state, w_nextState;
    logic [CW-1:0] r_count, w_nextCount;
    logic        r_controlReset, r_mretSignal, r_redirectValid, r_mcauseInterrupt;
    logic [3:0]  r_mcause;
    logic [31:0] r_mtval, r_trapPC, r_redirectPC;
    logic        w_irqSync, w_irqTake, w_idle, w_takeExc, w_takeIrq, w_takeMret, w_trap, w_event;

    trap_controller_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_d     (i_interrupt),
        .o_q     (w_irqSync)
    );

    always_comb begin
        w_irqTake   = w_irqSync & bus.mstatusMIE & bus.mieMEIE;
        w_idle      = (r_state == IDLE);
        w_takeExc   = w_idle & bus.writebackValid & bus.exceptionPending;
        w_takeIrq   = w_idle & bus.writebackValid & ~bus.exceptionPending & w_irqTake;
        w_takeMret  = w_idle & bus.writebackValid & ~bus.exceptionPending & ~w_irqTake & bus.mretValid;
        w_trap      = w_takeExc | w_takeIrq;
        w_event     = w_trap | w_takeMret;
        w_nextState = w_event ? FLUSH : (!w_idle && r_count == '0) ? IDLE : r_state;
        w_nextCount = w_event ? LOAD : (!w_idle && r_count != '0) ? r_count - 1'b1 : r_count;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state           <= IDLE;
            r_count           <= '0;
            r_controlReset    <= 1'b0;
            r_mretSignal      <= 1'b0;
            r_redirectValid   <= 1'b0;
            r_mcause          <= '0;
            r_mcauseInterrupt <= 1'b0;
            r_mtval           <= '0;
            r_trapPC          <= '0;
            r_redirectPC      <= '0;
        end else begin
            r_state         <= w_nextState;
            r_count         <= w_nextCount;
            r_controlReset  <= w_trap;
            r_mretSignal    <= w_takeMret;
            r_redirectValid <= w_event;
            if (w_trap) begin
                r_mcause          <= w_takeExc ? bus.exceptionCause : CAUSE_MEXT_INT;
                r_mcauseInterrupt <= ~w_takeExc;
                r_mtval           <= w_takeExc ? bus.exceptionTval : 32'd0;
                r_trapPC          <= bus.writebackPC;
            end
            if (w_event) r_redirectPC <= w_trap ? bus.trapVector : bus.mepcValue;
        end
    end

    // Wrong-path instructions during FLUSH must never commit.
    assign bus.commitSuppress  = !w_idle | w_trap;
    assign bus.controlReset    = r_controlReset;
    assign bus.mcause          = r_mcause;
    assign bus.mcauseInterrupt = r_mcauseInterrupt;
    assign bus.mtval           = r_mtval;
    assign bus.trapPC          = r_trapPC;
    assign bus.mretSignal      = r_mretSignal;
    assign bus.redirectValid   = r_redirectValid;
    assign bus.redirectPC      = r_redirectPC;
    assign bus.flush           = !w_idle;
    assign bus.busy            = !w_idle;
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: scoreboard bench for trap_controller
module tb_trap_controller;
    typedef struct packed {
        logic        trap;
        logic        mret;
        logic [3:0]  cause;
        logic        intr;
        logic [31:0] tval;
        logic [31:0] pc;
        logic [31:0] rpc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    trap_controller_if bus();

    trap_controller #(.FLUSH_CYCLES(3), .SYNC_STAGES(2)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_interrupt (irq),
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb();
        bus.writebackValid   = 1'b0;
        bus.exceptionPending = 1'b0;
        bus.mretValid        = 1'b0;
        bus.exceptionCause   = 4'd0;
        bus.exceptionTval    = 32'd0;
        bus.writebackPC      = 32'd0;
    endtask

    task automatic push_trap(input logic [3:0] cause, input logic intr, input logic [31:0] tval, input logic [31:0] pc);
        exp_t e;
        e = '{trap: 1'b1, mret: 1'b0, cause: cause, intr: intr, tval: tval, pc: pc, rpc: 32'h8000_0100};
        sb.push_back(e);
    endtask

    task automatic present_exc(input logic [3:0] cause, input logic [31:0] tval, input logic [31:0] pc);
        bus.writebackValid   = 1'b1;
        bus.exceptionPending = 1'b1;
        bus.exceptionCause   = cause;
        bus.exceptionTval    = tval;
        bus.writebackPC      = pc;
    endtask

    // Every strobe cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (bus.redirectValid || bus.controlReset || bus.mretSignal)) begin
            if (sb.size() == 0) begin
                check("sb_spurious_event", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_controlReset", bus.controlReset, e.trap);
                check("sb_mretSignal", bus.mretSignal, e.mret);
                check("sb_redirectValid", bus.redirectValid, 1'b1);
                check("sb_redirectPC", bus.redirectPC, e.rpc);
                if (e.trap) begin
                    check("sb_mcause", bus.mcause, e.cause);
                    check("sb_mcauseInterrupt", bus.mcauseInterrupt, e.intr);
                    check("sb_mtval", bus.mtval, e.tval);
                    check("sb_trapPC", bus.trapPC, e.pc);
                end
            end
        end
    end

    initial begin
        clear_wb();
        bus.mstatusMIE = 1'b0;
        bus.mieMEIE    = 1'b0;
        bus.trapVector = 32'h8000_0100;
        bus.mepcValue  = 32'h0;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_flush", bus.flush, 1'b0);
            check("rst_busy", bus.busy, 1'b0);
            check("rst_redirectPC", bus.redirectPC, 32'd0);
            check("rst_mcause", bus.mcause, 4'd0);
            check("rst_commitSuppress", bus.commitSuppress, 1'b0);
        end

        present_exc(4'd2, 32'hDEAD_BEEF, 32'h40);
        #1 check("exc_commitSuppress", bus.commitSuppress, 1'b1);
        push_trap(4'd2, 1'b0, 32'hDEAD_BEEF, 32'h40);
        tick();
        clear_wb();
        for (int i = 0; i < 3; i++) begin
            check("exc_flush", bus.flush, 1'b1);
            check("exc_busy", bus.busy, 1'b1);
            #1 check("exc_flush_suppress", bus.commitSuppress, 1'b1);
            tick();
        end
        check("exc_flush_end", bus.flush, 1'b0);
        check("exc_busy_end", bus.busy, 1'b0);
        check("exc_mcause_hold", bus.mcause, 4'd2);
        check("exc_ctrlrst_pulse", bus.controlReset, 1'b0);

        bus.mstatusMIE = 1'b1;
        bus.mieMEIE    = 1'b1;
        irq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("irq_nowb_busy", bus.busy, 1'b0);
            check("irq_nowb_suppress", bus.commitSuppress, 1'b0);
        end
        bus.writebackValid = 1'b1;
        bus.writebackPC    = 32'h60;
        #1 check("irq_commitSuppress", bus.commitSuppress, 1'b1);
        push_trap(4'd11, 1'b1, 32'd0, 32'h60);
        tick();
        clear_wb();
        irq = 1'b0;
        check("irq_flush", bus.flush, 1'b1);
        repeat (5) tick();
        check("irq_idle", bus.busy, 1'b0);

        irq = 1'b1;
        repeat (3) tick();
        present_exc(4'd5, 32'h1234, 32'h80);
        bus.mretValid = 1'b1;
        bus.mepcValue = 32'h44;
        push_trap(4'd5, 1'b0, 32'h1234, 32'h80);
        tick();
        clear_wb();
        repeat (3) tick();
        bus.mstatusMIE = 1'b0;
        bus.writebackValid = 1'b1;
        bus.writebackPC    = 32'h90;
        #1 check("irq_masked_suppress", bus.commitSuppress, 1'b0);
        tick();
        check("irq_masked_busy", bus.busy, 1'b0);
        present_exc(4'd7, 32'h77, 32'h94);
        push_trap(4'd7, 1'b0, 32'h77, 32'h94);
        tick();
        clear_wb();
        irq = 1'b0;
        repeat (4) tick();

        bus.writebackValid = 1'b1;
        bus.mretValid      = 1'b1;
        bus.writebackPC    = 32'hA0;
        #1 check("mret_commitSuppress", bus.commitSuppress, 1'b0);
        sb.push_back('{trap: 1'b0, mret: 1'b1, cause: 4'd0, intr: 1'b0, tval: 32'd0, pc: 32'd0, rpc: 32'h44});
        tick();
        clear_wb();
        tick();
        present_exc(4'd3, 32'h33, 32'hB0);
        #1 check("flush_ignore_suppress", bus.commitSuppress, 1'b1);
        tick();
        clear_wb();
        repeat (2) tick();
        check("mret_idle", bus.busy, 1'b0);

        present_exc(4'd4, 32'h44, 32'hC0);
        push_trap(4'd4, 1'b0, 32'h44, 32'hC0);
        tick();
        clear_wb();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_flush", bus.flush, 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        tick();
        present_exc(4'd6, 32'h66, 32'hD0);
        push_trap(4'd6, 1'b0, 32'h66, 32'hD0);
        tick();
        clear_wb();
        check("post_rst_flush", bus.flush, 1'b1);
        repeat (4) tick();
        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
